alu_issue_ctrl: RTL

//  Initiator side of the alu_16bit interface. Accepts 16-bit instructions over a valid/ready

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/regfile_8x16.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode map, FSM encoding and decode helpers for the alu_16bit issue controller.
// The opcode numbering matches the mux select ordering inside alu_16bit.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_SUB = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_DEC = 4'd4;
   localparam logic [3:0] OP_INC = 4'd5;
   localparam logic [3:0] OP_INV = 4'd6;
   localparam logic [3:0] OP_LI  = 4'd7;
   localparam logic [3:0] OP_LSL = 4'd8;
   localparam logic [3:0] OP_SLT = 4'd9;
   localparam logic [3:0] OP_LSR = 4'd10;
   localparam logic [3:0] OP_NOP_B = 4'd11;
   localparam logic [3:0] OP_ASL = 4'd12;
   localparam logic [3:0] OP_NOP_D = 4'd13;
   localparam logic [3:0] OP_ASR = 4'd14;
   localparam logic [3:0] OP_NOP_F = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Opcodes 11/13/15 are holes in the ALU mux and are treated as no-ops.
   function automatic logic is_nop_op(input logic [3:0] op);
      return (op == OP_NOP_B) || (op == OP_NOP_D) || (op == OP_NOP_F);
   endfunction

   // Everything except LI and the no-op holes goes through the ALU.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op != OP_LI) && !is_nop_op(op);
   endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file with two operand read ports, one debug read port and one synchronous write.
// Register 0 always reads as zero and ignores writes.
module regfile_8x16
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rd_addr_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   input  logic [REG_AW-1:0] dbg_addr,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NUM_REGS = 2 ** REG_AW;

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Storage: cleared on reset, written on the clock edge, writes to r0 discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Asynchronous reads, with r0 forced to zero regardless of array contents.
   always_comb begin
      rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
      rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
      dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single combinational alu_16bit: accepts an instruction, drives the
// ALU operands for one cycle, writes the result back and hands it to the consumer.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [3:0]        ALUCtrl,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] S,
   input  logic              Overflow,
   input  logic              Zero,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] result,
   output logic              flag_ovf,
   output logic              flag_zero,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t state;
   state_t state_next;

   logic [3:0]        instr_op;
   logic [REG_AW-1:0] instr_rd;
   logic [REG_AW-1:0] instr_rs;
   logic [REG_AW-1:0] instr_rt;
   logic [8:0]        instr_imm9;
   logic [DATA_W-1:0] imm_ext;
   logic              accept;

   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] rf_data_a;
   logic [DATA_W-1:0] rf_data_b;
   logic              wr_en;
   logic [REG_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign instr_op   = instr[15:12];
   assign instr_rd   = instr[11:9];
   assign instr_rs   = instr[8:6];
   assign instr_rt   = instr[5:3];
   assign instr_imm9 = instr[8:0];
   assign imm_ext    = {{(DATA_W-9){1'b0}}, instr_imm9};
   assign accept     = (state == ST_IDLE) && instr_valid;

   regfile_8x16 #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (instr_rs),
      .rd_addr_b (instr_rt),
      .dbg_addr  (dbg_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data_a (rf_data_a),
      .rd_data_b (rf_data_b),
      .dbg_data  (dbg_data)
   );

   // State register; reset abandons whatever instruction is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; LI/NOP skip EXEC since they never touch the ALU.
   always_comb begin
      state_next   = state;
      instr_ready  = 1'b0;
      result_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_next = is_alu_op(instr_op) ? ST_EXEC : ST_RESP;
            end
         end
         ST_EXEC: begin
            state_next = ST_RESP;
         end
         ST_RESP: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Write-back port: LI writes at the accept edge, ALU ops at the end of EXEC.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = instr_rd;
      wr_data = imm_ext;
      if (!rst) begin
         if (accept && (instr_op == OP_LI)) begin
            wr_en = 1'b1;
         end else if (state == ST_EXEC) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = S;
         end
      end
   end

   // Operand/result/flag registers; A, B and ALUCtrl only change when an ALU op is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALUCtrl   <= '0;
         A         <= '0;
         B         <= '0;
         rd_q      <= '0;
         result    <= '0;
         flag_ovf  <= 1'b0;
         flag_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  if (is_alu_op(instr_op)) begin
                     A       <= rf_data_a;
                     B       <= rf_data_b;
                     ALUCtrl <= instr_op;
                     rd_q    <= instr_rd;
                  end else if (instr_op == OP_LI) begin
                     result    <= imm_ext;
                     flag_ovf  <= 1'b0;
                     flag_zero <= (instr_imm9 == 9'd0);
                  end else begin
                     result <= '0;
                  end
               end
            end
            ST_EXEC: begin
               result    <= S;
               flag_ovf  <= Overflow;
               flag_zero <= Zero;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
